// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between the board control logic and alu_sequencer.
// ALU_SEQ_CHAIN_EN adds cmd_chain to the command channel.
interface alu_sequencer_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
  logic         cmd_chain;
`endif
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_nzcv;
  logic         rsp_err;

`ifdef ALU_SEQ_CHAIN_EN
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_nzcv, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_nzcv, rsp_err
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_nzcv, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_nzcv, rsp_err
  );
`endif
endinterface

// File: rtl/alu_sequencer.sv
// Drives a combinational ALU with one latched command, waits SETTLE cycles, captures
// result/NZCV into a response register. Optional macro ALU_SEQ_CHAIN_EN enables cmd_chain.
module alu_sequencer #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_sequencer_if.slave bus,
  output logic [W-1:0]  alu_A,
  output logic [W-1:0]  alu_B_inv,
  output logic [3:0]    alu_op,
  input  logic [W-1:0]  alu_result,
  input  logic [3:0]    alu_nzcv,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t       state;
  logic [3:0]   cnt;
  logic [W-1:0] b_q;
  logic [W-1:0] a_sel;
  logic         div0;

  assign bus.cmd_ready = (state == IDLE) && rst_n;
  assign alu_B_inv     = ~b_q;
  assign div0          = ((bus.cmd_op == 4'b0011) || (bus.cmd_op == 4'b0100)) &&
                         (bus.cmd_b == '0);

`ifdef ALU_SEQ_CHAIN_EN
  logic [W-1:0] last_res;
  assign a_sel = bus.cmd_chain ? last_res : bus.cmd_a;
`else
  assign a_sel = bus.cmd_a;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      alu_A          <= '0;
      b_q            <= '0;
      alu_op         <= '0;
      busy           <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_nzcv   <= '0;
      bus.rsp_err    <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
      last_res       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            busy <= 1'b1;
            // Zero-divisor commands short-circuit: the ALU inputs keep the previous command.
            if (div0) begin
              state          <= RESP;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_result <= '0;
              bus.rsp_nzcv   <= 4'b0100;
              bus.rsp_err    <= 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
              last_res       <= '0;
`endif
            end else begin
              state  <= DRIVE;
              cnt    <= CNT_INIT;
              alu_A  <= a_sel;
              b_q    <= bus.cmd_b;
              alu_op <= bus.cmd_op;
            end
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            state          <= RESP;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_result <= alu_result;
            bus.rsp_nzcv   <= alu_nzcv;
            bus.rsp_err    <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            last_res       <= alu_result;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
